// File: rtl/elastic_pipeline_v.sv
// elastic_pipeline_v: chain of STAGES valid/ready pipeline registers.
// Each stage advances whenever it is empty or the stage after it can take
// its word, so bubbles collapse and a stall at the output back-pressures
// the producer. With SKID_INPUT=1 an extra input register holds one word,
// which lets In_ready come from flops instead of from Out_ready.
module elastic_pipeline_v #(
   parameter int WORD_LENGTH = 8,
   parameter int STAGES      = 3,
   parameter int SKID_INPUT  = 0
) (
   input  logic                                        Clock,
   input  logic                                        Reset,
   input  logic                                        Flush,
   input  logic [WORD_LENGTH-1:0]                      In_data,
   input  logic                                        In_valid,
   output logic                                        In_ready,
   output logic [WORD_LENGTH-1:0]                      Out_data,
   output logic                                        Out_valid,
   input  logic                                        Out_ready,
   output logic [$clog2(STAGES+SKID_INPUT+1)-1:0]      Occupancy
);

   localparam int OW = $clog2(STAGES + SKID_INPUT + 1);

   generate
      if (WORD_LENGTH < 1 || STAGES < 1) begin : g_bad_params
         $error("elastic_pipeline_v: WORD_LENGTH and STAGES must both be >= 1");
      end
   endgenerate

   logic [STAGES-1:0]      v_q, v_d;
   logic [WORD_LENGTH-1:0] d_q [STAGES];
   logic [WORD_LENGTH-1:0] d_d [STAGES];
   logic                   skid_v_q, skid_v_d;
   logic [WORD_LENGTH-1:0] skid_data_q, skid_data_d;
   logic                   alive_q, alive_d;
   logic [OW-1:0]          occ_q, occ_d;

   logic [STAGES-1:0]      rdy_s;
   logic                   chain_s;
   logic                   in_ready_s;
   logic                   accept_s;
   logic                   src_v_s;
   logic [WORD_LENGTH-1:0] src_d_s;

   // Ready chain: a stage can load when it is empty or its successor can load.
   always_comb begin
      rdy_s   = '0;
      chain_s = Out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         chain_s  = ~v_q[k] | chain_s;
         rdy_s[k] = chain_s;
      end
   end

   // Input handshake and the word offered to stage 0 (skid has priority).
   always_comb begin
      if (SKID_INPUT != 0) begin
         in_ready_s = alive_q & ~skid_v_q & ~Flush;
      end else begin
         in_ready_s = alive_q & rdy_s[0] & ~Flush;
      end
      accept_s = In_valid & in_ready_s;
      if ((SKID_INPUT != 0) && skid_v_q) begin
         src_v_s = 1'b1;
         src_d_s = skid_data_q;
      end else begin
         src_v_s = accept_s;
         src_d_s = In_data;
      end
   end

   // Next state for stages, skid, occupancy; Flush drops every held word.
   always_comb begin
      v_d         = v_q;
      d_d         = d_q;
      skid_v_d    = skid_v_q;
      skid_data_d = skid_data_q;
      alive_d     = 1'b1;
      occ_d       = '0;

      if (rdy_s[0]) begin
         v_d[0] = src_v_s;
         if (src_v_s) begin
            d_d[0] = src_d_s;
         end else begin
            d_d[0] = d_q[0];
         end
      end else begin
         v_d[0] = v_q[0];
         d_d[0] = d_q[0];
      end

      for (int k = 1; k < STAGES; k++) begin
         if (rdy_s[k]) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) begin
               d_d[k] = d_q[k-1];
            end else begin
               d_d[k] = d_q[k];
            end
         end else begin
            v_d[k] = v_q[k];
            d_d[k] = d_q[k];
         end
      end

      if (SKID_INPUT != 0) begin
         if (skid_v_q) begin
            if (rdy_s[0]) begin
               skid_v_d = 1'b0;
            end else begin
               skid_v_d = 1'b1;
            end
         end else if (accept_s && !rdy_s[0]) begin
            skid_v_d    = 1'b1;
            skid_data_d = In_data;
         end else begin
            skid_v_d = 1'b0;
         end
      end else begin
         skid_v_d = 1'b0;
      end

      if (Flush) begin
         v_d      = '0;
         skid_v_d = 1'b0;
      end else begin
         v_d      = v_d;
      end

      for (int k = 0; k < STAGES; k++) begin
         occ_d = occ_d + OW'(v_d[k]);
      end
      occ_d = occ_d + OW'(skid_v_d);
   end

   // State registers; asynchronous reset empties the pipe immediately.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         v_q         <= '0;
         skid_v_q    <= 1'b0;
         skid_data_q <= '0;
         alive_q     <= 1'b0;
         occ_q       <= '0;
         for (int k = 0; k < STAGES; k++) begin
            d_q[k] <= '0;
         end
      end else begin
         v_q         <= v_d;
         skid_v_q    <= skid_v_d;
         skid_data_q <= skid_data_d;
         alive_q     <= alive_d;
         occ_q       <= occ_d;
         for (int k = 0; k < STAGES; k++) begin
            d_q[k] <= d_d[k];
         end
      end
   end

   assign In_ready  = in_ready_s;
   assign Out_data  = d_q[STAGES-1];
   assign Out_valid = v_q[STAGES-1];
   assign Occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipeline_v.sv
// Bench for elastic_pipeline_v: dut1 is STAGES=3/no skid, dut2 adds the skid.
// dut1 output is scored by a monitor against a queue of accepted words.
module tb_elastic_pipeline_v;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       flush1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
   logic [7:0] in_data1 = 8'h00;
   logic       in_ready1, out_valid1;
   logic [7:0] out_data1;
   logic [1:0] occ1;

   logic       flush2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b0;
   logic [7:0] in_data2 = 8'h00;
   logic       in_ready2, out_valid2;
   logic [7:0] out_data2;
   logic [2:0] occ2;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] sb[$];
   logic       stall_r = 1'b0;
   logic [7:0] held_r = 8'h00;

   always #5 clk = ~clk;

   elastic_pipeline_v #(.WORD_LENGTH(8), .STAGES(3), .SKID_INPUT(0)) dut1 (
      .Clock(clk), .Reset(rst_n), .Flush(flush1),
      .In_data(in_data1), .In_valid(in_valid1), .In_ready(in_ready1),
      .Out_data(out_data1), .Out_valid(out_valid1), .Out_ready(out_ready1),
      .Occupancy(occ1));

   elastic_pipeline_v #(.WORD_LENGTH(8), .STAGES(3), .SKID_INPUT(1)) dut2 (
      .Clock(clk), .Reset(rst_n), .Flush(flush2),
      .In_data(in_data2), .In_valid(in_valid2), .In_ready(in_ready2),
      .Out_data(out_data2), .Out_valid(out_valid2), .Out_ready(out_ready2),
      .Occupancy(occ2));

   // Scoreboard monitor for dut1: order, stability under stall, occupancy.
   always @(posedge clk) begin
      if (rst_n) begin
         checks++;
         if (int'(occ1) != sb.size()) begin
            errors++;
            $display("FAIL occupancy: got %0d expected %0d", occ1, sb.size());
         end
         if (stall_r && out_valid1) begin
            checks++;
            if (out_data1 !== held_r) begin
               errors++;
               $display("FAIL stall_stable: got %02h expected %02h", out_data1, held_r);
            end
         end
         if (out_valid1 && out_ready1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word: got %02h expected none", out_data1);
            end else begin
               logic [7:0] exp_w;
               exp_w = sb.pop_front();
               if (out_data1 !== exp_w) begin
                  errors++;
                  $display("FAIL order: got %02h expected %02h", out_data1, exp_w);
               end
            end
         end
         if (in_valid1 && in_ready1) sb.push_back(in_data1);
         stall_r <= out_valid1 && !out_ready1 && !flush1;
         held_r  <= out_data1;
      end else begin
         stall_r <= 1'b0;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_idle1();
      in_valid1  = 1'b0;
      out_ready1 = 1'b1;
      for (int c = 0; c < 50 && (occ1 != 2'd0 || sb.size() != 0); c++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #13;
      checks += 4;
      if (out_valid1 !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid1); end
      if (in_ready1 !== 1'b0)  begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready1); end
      if (occ1 !== 2'd0)       begin errors++; $display("FAIL rst_occ: got %0d expected 0", occ1); end
      if (in_ready2 !== 1'b0)  begin errors++; $display("FAIL rst_in_ready_skid: got %b expected 0", in_ready2); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks += 2;
      if (in_ready1 !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready1); end
      if (in_ready2 !== 1'b1) begin errors++; $display("FAIL release_in_ready_skid: got %b expected 1", in_ready2); end
   endtask

   task automatic test_back_to_back();
      int acc = 0;
      out_ready1 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data1  = 8'(i + 1);
         in_valid1 = 1'b1;
         #1;
         if (in_ready1) acc++;
         @(posedge clk); #1;
         if (i == 1) begin
            checks++;
            if (out_valid1 !== 1'b0) begin errors++; $display("FAIL latency_early: got %b expected 0", out_valid1); end
         end
         if (i == 2) begin
            checks++;
            if (out_valid1 !== 1'b1 || out_data1 !== 8'h01) begin
               errors++;
               $display("FAIL latency: got v=%b d=%02h expected v=1 d=01", out_valid1, out_data1);
            end
         end
      end
      checks++;
      if (acc != 16) begin errors++; $display("FAIL throughput: got %0d accepted expected 16", acc); end
      wait_idle1();
      checks++;
      if (sb.size() != 0 || occ1 !== 2'd0) begin errors++; $display("FAIL b2b_drain: got %0d left expected 0", sb.size()); end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      logic [7:0] nxt = 8'h01;
      out_ready1 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_data1  = nxt;
         in_valid1 = 1'b1;
         #1;
         if (in_ready1) begin acc++; nxt = nxt + 8'h01; end
         @(posedge clk); #1;
      end
      checks += 3;
      if (acc != 3)           begin errors++; $display("FAIL bp_accepted: got %0d expected 3", acc); end
      if (in_ready1 !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready1); end
      if (occ1 !== 2'd3)      begin errors++; $display("FAIL bp_occ: got %0d expected 3", occ1); end
      wait_idle1();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d left expected 0", sb.size()); end
   endtask

   task automatic test_skid();
      logic [7:0] q2[$];
      logic [7:0] nxt = 8'h01;
      int acc = 0;
      logic took;
      out_ready2 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         in_data2  = nxt;
         in_valid2 = 1'b1;
         #1;
         took = in_ready2;
         if (took) begin acc++; q2.push_back(nxt); nxt = nxt + 8'h01; end
         @(posedge clk); #1;
         if (took && acc == 3) begin
            checks++;
            if (in_ready2 !== 1'b1) begin errors++; $display("FAIL skid_ready3: got %b expected 1", in_ready2); end
         end
         if (took && acc == 4) begin
            checks++;
            if (in_ready2 !== 1'b0) begin errors++; $display("FAIL skid_ready4: got %b expected 0", in_ready2); end
         end
      end
      in_valid2 = 1'b0;
      checks += 2;
      if (acc != 4)      begin errors++; $display("FAIL skid_accepted: got %0d expected 4", acc); end
      if (occ2 !== 3'd4) begin errors++; $display("FAIL skid_occ: got %0d expected 4", occ2); end
      out_ready2 = 1'b1;
      #1;
      checks++;
      if (in_ready2 !== 1'b0) begin errors++; $display("FAIL skid_comb_path: got %b expected 0", in_ready2); end
      for (int c = 0; c < 20 && q2.size() != 0; c++) begin
         if (out_valid2) begin
            logic [7:0] e;
            e = q2.pop_front();
            checks++;
            if (out_data2 !== e) begin errors++; $display("FAIL skid_order: got %02h expected %02h", out_data2, e); end
         end
         @(posedge clk); #2;
      end
      checks++;
      if (q2.size() != 0 || occ2 !== 3'd0) begin
         errors++;
         $display("FAIL skid_drain: got %0d left occ %0d expected 0", q2.size(), occ2);
      end
   endtask

   task automatic test_random();
      int acc = 0;
      for (int c = 0; c < 60000 && acc < 10000; c++) begin
         in_valid1  = 1'($urandom_range(0, 1));
         in_data1   = 8'($urandom_range(0, 255));
         out_ready1 = 1'($urandom_range(0, 1));
         #1;
         if (in_valid1 && in_ready1) acc++;
         @(posedge clk); #1;
      end
      checks++;
      if (acc != 10000) begin errors++; $display("FAIL rand_count: got %0d expected 10000", acc); end
      wait_idle1();
      checks++;
      if (sb.size() != 0 || occ1 !== 2'd0) begin errors++; $display("FAIL rand_drain: got %0d left expected 0", sb.size()); end
   endtask

   task automatic test_flush();
      logic seen = 1'b0;
      out_ready1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_data1  = 8'(8'h11 * (i + 1));
         in_valid1 = 1'b1;
         @(posedge clk); #1;
      end
      flush1    = 1'b1;
      in_data1  = 8'hAA;
      in_valid1 = 1'b1;
      #1;
      checks += 2;
      if (occ1 !== 2'd2)      begin errors++; $display("FAIL flush_pre_occ: got %0d expected 2", occ1); end
      if (in_ready1 !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready1); end
      @(posedge clk); #1;
      flush1    = 1'b0;
      in_valid1 = 1'b0;
      sb.delete();
      checks += 2;
      if (occ1 !== 2'd0)       begin errors++; $display("FAIL flush_occ: got %0d expected 0", occ1); end
      if (out_valid1 !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid1); end
      out_ready1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (out_valid1) seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL flush_leak: got output expected none"); end
   endtask

   task automatic test_reset_midstream();
      out_ready1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data1  = 8'(8'h21 + i);
         in_valid1 = 1'b1;
         @(posedge clk); #1;
      end
      in_valid1 = 1'b0;
      checks++;
      if (occ1 !== 2'd3) begin errors++; $display("FAIL mid_pre_occ: got %0d expected 3", occ1); end
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      checks += 3;
      if (out_valid1 !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid1); end
      if (occ1 !== 2'd0)       begin errors++; $display("FAIL mid_occ: got %0d expected 0", occ1); end
      if (in_ready1 !== 1'b0)  begin errors++; $display("FAIL mid_in_ready: got %b expected 0", in_ready1); end
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready1 !== 1'b1) begin errors++; $display("FAIL mid_release: got %b expected 1", in_ready1); end
      out_ready1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data1  = 8'(8'h31 + i);
         in_valid1 = 1'b1;
         @(posedge clk); #1;
      end
      wait_idle1();
      checks++;
      if (sb.size() != 0 || occ1 !== 2'd0) begin errors++; $display("FAIL mid_fresh: got %0d left expected 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_skid();
      test_random();
      test_flush();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
